// File: rtl/radix4_pkg.sv
// -----------------------------------------------------------------------------
// radix4_pkg
//   Shared definitions for the serial radix-4 recoding datapath and its
//   sequencing controller.
//
//   Contents:
//     ctrl_state_t     controller state encoding (IDLE, LOAD, RUN, DONE)
//     num_steps()      number of digit steps for an operand width
//     digit_idx_width() width of the digit index seen by the datapath
//
//   Configuration macro: RECODE_SIGNED_EN
//     defined   -> two's-complement operand. The recoding absorbs the sign of
//                  the top digit, so there are WIDTH/2 steps.
//     undefined -> unsigned operand. One extra carry-only digit is needed,
//                  so there are WIDTH/2+1 steps.
// -----------------------------------------------------------------------------
package radix4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

  // Number of radix-4 digit steps needed for one operation.
  function automatic int num_steps(input int width);
`ifdef RECODE_SIGNED_EN
    return width / 2;
`else
    return width / 2 + 1;
`endif
  endfunction

  // The index is sized for WIDTH/2+2 values. That covers both the signed and
  // the unsigned step counts, so the datapath port width does not change
  // with the macro.
  function automatic int digit_idx_width(input int width);
    return $clog2(width / 2 + 2);
  endfunction

endpackage

// File: rtl/radix4_seq_ctrl_digit_counter.sv
// -----------------------------------------------------------------------------
// digit_counter
//   Digit index counter for the radix-4 sequencing controller.
//   It saturates at LAST, so the index can never pass the final digit.
//
//   Ports:
//     clk  in   rising-edge clock
//     rst  in   asynchronous active-high reset; counter goes to 0
//     clr  in   synchronous clear to 0; overrides en
//     en   in   advance by one; no effect once the count is at LAST
//     cnt  out  current digit index
//     tc   out  terminal count, high when cnt == LAST
// -----------------------------------------------------------------------------
module digit_counter #(
  parameter int CNT_W = 3,
  parameter int LAST  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(LAST);
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

  assign tc = (cnt == LAST_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + ONE_V;
    end
  end

endmodule

// File: rtl/radix4_seq_ctrl.sv
// -----------------------------------------------------------------------------
// radix4_seq_ctrl
//   Sequencing controller for the serial radix-4 recoding datapath.
//   It accepts one request at a time. It pulses load to the operand shift
//   register and carry stage, then steps the datapath once per digit. At the
//   end it holds done until the consumer acks. This block is the only driver
//   of the datapath's load and step enables.
//
//   Configuration macro: RECODE_SIGNED_EN
//     Selects N = WIDTH/2 steps (signed) or N = WIDTH/2+1 steps (unsigned).
//     The choice is made in radix4_pkg::num_steps.
//
//   Ports:
//     clk         in   rising-edge clock
//     rst         in   asynchronous active-high reset
//     start       in   request; accepted when start & req_ready
//     req_ready   out  idle, can accept start
//     abort       in   cancel any operation; beats start, stall, ack and the
//                      last step
//     stall       in   downstream not ready; freezes stepping in RUN
//     load        out  one-cycle pulse; datapath loads operand, clears carry
//     step        out  datapath shifts 2 bits / consumes one digit
//     digit_idx   out  index of the digit consumed this step (0 outside RUN)
//     last_digit  out  current step is the final digit
//     busy        out  operation in progress (LOAD or RUN)
//     done        out  result valid; held until ack
//     ack         in   consumer takes the result
//     dbg_state   out  current controller state, for observation only
//
//   Handshake: an operation starts on a cycle where start & req_ready are
//   both high. The result is handed over on a cycle where done & ack are
//   both high. After that cycle the controller is idle again. Outside these
//   cycles, start and ack are ignored.
// -----------------------------------------------------------------------------
module radix4_seq_ctrl
  import radix4_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = digit_idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             req_ready,
  input  logic             abort,
  input  logic             stall,
  output logic             load,
  output logic             step,
  output logic [CNT_W-1:0] digit_idx,
  output logic             last_digit,
  output logic             busy,
  output logic             done,
  input  logic             ack,
  output ctrl_state_t      dbg_state
);

  localparam int N = num_steps(WIDTH);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("radix4_seq_ctrl: WIDTH must be even and at least 4");
  end

  ctrl_state_t      state;
  ctrl_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;
  logic             cnt_clr;

  // ---------------------------------------------------------------------------
  // Digit index counter.
  // It is held at zero in every state except RUN. That clears it in LOAD and
  // forces it back to zero after DONE or an abort. The explicit abort term
  // keeps the clear immediate, even if the clear condition is changed later.
  // ---------------------------------------------------------------------------
  assign cnt_clr = (state != RUN) || abort;

  digit_counter #(
    .CNT_W (CNT_W),
    .LAST  (N - 1)
  ) u_digit_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (step),
    .cnt (cnt),
    .tc  (cnt_tc)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. abort is checked first, so it overrides every other
  // transition, including the final step into DONE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start)            state_nxt = LOAD;
        LOAD:                       state_nxt = RUN;
        RUN:  if (!stall && cnt_tc) state_nxt = DONE;
        DONE: if (ack)              state_nxt = IDLE;
        default:                    state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. The outputs depend only on the registered state and the
  // counter. The one exception is stall: it gates step in RUN, so a stalled
  // cycle consumes no digit.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready  = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    digit_idx  = '0;
    last_digit = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
      end
      LOAD: begin
        load = 1'b1;
        busy = 1'b1;
      end
      RUN: begin
        busy       = 1'b1;
        step       = !stall;
        digit_idx  = cnt;
        last_digit = !stall && cnt_tc;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_radix4_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_radix4_seq_ctrl
//   Self-checking bench for radix4_seq_ctrl.
//
//   Reference model: each operation is described as a timeline. It has one
//   accept cycle and one load cycle. Then come N digit steps, and random or
//   directed stall cycles may be placed before any step. Then done is held
//   for a chosen number of cycles before ack. An abort cuts the timeline
//   short.
//
//   The driver plays this timeline cycle by cycle. Each cycle it publishes
//   the expected levels and pushes the expected load/step/done events into a
//   scoreboard queue. A monitor on the falling edge compares the DUT levels
//   and pops an event whenever load or step fires or done rises.
// -----------------------------------------------------------------------------
module tb_radix4_seq_ctrl;
  import radix4_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH / 2 + 2);
`ifdef RECODE_SIGNED_EN
  localparam int N = WIDTH / 2;
`else
  localparam int N = WIDTH / 2 + 1;
`endif
  localparam int W = CNT_W + 3;

  localparam logic [1:0]       EV_LOAD = 2'd1;
  localparam logic [1:0]       EV_STEP = 2'd2;
  localparam logic [1:0]       EV_DONE = 2'd3;
  localparam logic [CNT_W-1:0] ZI      = '0;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             stall = 1'b0;
  logic             ack   = 1'b0;
  logic             req_ready;
  logic             load;
  logic             step;
  logic [CNT_W-1:0] digit_idx;
  logic             last_digit;
  logic             busy;
  logic             done;
  ctrl_state_t      dbg_state;

  radix4_seq_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .req_ready  (req_ready),
    .abort      (abort),
    .stall      (stall),
    .load       (load),
    .step       (step),
    .digit_idx  (digit_idx),
    .last_digit (last_digit),
    .busy       (busy),
    .done       (done),
    .ack        (ack),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [W-1:0]     exp_q[$];
  logic             mon_en  = 1'b0;
  logic             m_ready = 1'b1;
  logic             m_busy  = 1'b0;
  logic             m_load  = 1'b0;
  logic             m_step  = 1'b0;
  logic             m_last  = 1'b0;
  logic             m_done  = 1'b0;
  logic [CNT_W-1:0] m_idx   = '0;
  logic             done_d  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    check({name, "_expected"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(name, 32'(act), 32'(e));
    end
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_digit_idx", 32'(digit_idx), 32'd0);
    check("rst_last_digit", 32'(last_digit), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("req_ready", 32'(req_ready), 32'(m_ready));
      check("busy", 32'(busy), 32'(m_busy));
      check("load", 32'(load), 32'(m_load));
      check("step", 32'(step), 32'(m_step));
      check("last_digit", 32'(last_digit), 32'(m_last));
      check("done", 32'(done), 32'(m_done));
      check("digit_idx", 32'(digit_idx), 32'(m_idx));
      if (load) sb_pop("load_event", {EV_LOAD, 1'b0, ZI});
      if (step) sb_pop("step_event", {EV_STEP, last_digit, digit_idx});
      if (done && !done_d) sb_pop("done_event", {EV_DONE, 1'b0, digit_idx});
    end
    done_d = done;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle of inputs plus the expected levels for that cycle.
  task automatic cyc_drive(input logic s, input logic a, input logic st, input logic ak,
                           input logic r, input logic b, input logic ld, input logic sp,
                           input logic lst, input logic dn, input logic [CNT_W-1:0] ix);
    start = s; abort = a; stall = st; ack = ak;
    m_ready = r; m_busy = b; m_load = ld; m_step = sp;
    m_last = lst; m_done = dn; m_idx = ix;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    cyc_drive(1'b0, rb(), rb(), rb(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ZI);
  endtask

  // One operation from an idle cycle.
  //   stall_pct : chance (percent) of stall cycles before each step
  //   stall_idx : digit that gets exactly stall_len stalls (-1: none)
  //   ack_wait  : DONE cycles with ack low before the ack cycle
  //   abort_at  : -1 none, -2 abort in LOAD, k abort on the step of digit k
  task automatic run_op(input int stall_pct, input int stall_idx, input int stall_len,
                        input int ack_wait, input int abort_at);
    logic [CNT_W-1:0] ix;
    logic             lst;
    int               nst;
    cyc_drive(1'b1, 1'b0, rb(), rb(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ZI);
    exp_q.push_back({EV_LOAD, 1'b0, ZI});
    if (abort_at == -2) begin
      cyc_drive(rb(), 1'b1, rb(), rb(), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ZI);
      return;
    end
    cyc_drive(rb(), 1'b0, rb(), rb(), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ZI);
    for (int k = 0; k < N; k++) begin
      ix  = CNT_W'(k);
      lst = (k == N - 1);
      nst = 0;
      if (k == stall_idx) begin
        nst = stall_len;
      end else begin
        while ((nst < 4) && (int'($urandom_range(1, 100)) <= stall_pct)) nst++;
      end
      for (int s = 0; s < nst; s++)
        cyc_drive(rb(), 1'b0, 1'b1, rb(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ix);
      exp_q.push_back({EV_STEP, lst, ix});
      cyc_drive(rb(), (k == abort_at), 1'b0, rb(), 1'b0, 1'b1, 1'b0, 1'b1, lst, 1'b0, ix);
      if (k == abort_at) return;
    end
    exp_q.push_back({EV_DONE, 1'b0, ZI});
    for (int w = 0; w <= ack_wait; w++)
      cyc_drive(rb(), 1'b0, rb(), (w == ack_wait), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ZI);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    #1 rst = 1'b1;
    #2 check_reset_vals();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    idle_cycle();
    idle_cycle();

    run_op(0, -1, 0, 0, -1);          // plain sequence, ack at DONE entry
    idle_cycle();
    run_op(0, 2, 3, 0, -1);           // 3 stalls holding digit 2
    run_op(0, -1, 0, 10, -1);         // ack withheld, start ignored in DONE
    run_op(0, -1, 0, 0, 1);           // abort at digit 1
    run_op(0, -1, 0, 0, -1);          // full sequence straight after abort
    run_op(0, -1, 0, 0, -2);          // abort in LOAD
    // abort beats start in IDLE: nothing is accepted
    cyc_drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ZI);
    idle_cycle();
    run_op(0, N - 1, 2, 1, -1);       // stall on the last digit
    run_op(0, -1, 0, 0, N - 1);       // abort on the last step: no done

    // Asynchronous reset in the middle of RUN
    cyc_drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ZI);
    exp_q.push_back({EV_LOAD, 1'b0, ZI});
    cyc_drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ZI);
    exp_q.push_back({EV_STEP, 1'b0, ZI});
    cyc_drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ZI);
    exp_q.push_back({EV_STEP, 1'b0, CNT_W'(1)});
    cyc_drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, CNT_W'(1));
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_vals();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) idle_cycle();
    run_op(0, -1, 0, 0, -1);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      int gap;
      int abt;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) idle_cycle();
      abt = -1;
      if ($urandom_range(0, 4) == 0) abt = int'($urandom_range(0, N)) - 1;
      if (abt == -1 && $urandom_range(0, 1) == 0) abt = -1;
      else if (abt == -1) abt = -2;
      if ($urandom_range(0, 2) != 0 && abt == -2) abt = -1;
      run_op(int'($urandom_range(0, 40)), -1, 0, int'($urandom_range(0, 3)), abt);
    end
    idle_cycle();
    idle_cycle();

    mon_en = 1'b0;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
